// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: register file, PC/IR/MAR/MDR/Y/HI/LO/Z around one shared bus plus a combinational ALU.
// Latency: bus and ALU are combinational; every register updates on the rising edge after its load strobe.
// No backpressure: all selects and strobes come from an external sequencer, one register transfer per clock.
module data_path (
  input  logic        Clock,
  input  logic        Clear,
  input  logic        PCout,
  input  logic        ZHighout,
  input  logic        Zlowout,
  input  logic        MDRout,
  input  logic        R2out,
  input  logic        R3out,
  input  logic        R4out,
  input  logic        R5out,
  input  logic        R6out,
  input  logic        R7out,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        MDRin,
  input  logic        IRin,
  input  logic        Yin,
  input  logic        IncPC,
  input  logic        Read,
  input  logic [4:0]  DIV,
  input  logic        R1in,
  input  logic        R2in,
  input  logic        R3in,
  input  logic        R4in,
  input  logic        R5in,
  input  logic        R6in,
  input  logic        R7in,
  input  logic        R8in,
  input  logic        R9in,
  input  logic        R10in,
  input  logic        R11in,
  input  logic        R12in,
  input  logic        R13in,
  input  logic        R14in,
  input  logic        R15in,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        ZHighIn,
  input  logic        ZLowIn,
  input  logic        Cin,
  input  logic [31:0] Mdatain,
  output logic [31:0] BusMuxOut
);

  // R0 is hardwired to zero, so it has no storage here.
  logic [31:0] rf [1:15];
  logic [31:0] pc, ir, mar, mdr, y, hi, lo, zhigh, zlow;
  logic [15:1] rf_in;
  logic [31:0] bus;
  logic [63:0] alu_res;

  logic [4:0]         amt;
  logic [63:0]        rol_w, ror_w;
  logic signed [63:0] prod;
  logic signed [31:0] quo, rem;
  logic               div_zero, div_ovf;

  assign rf_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in, R6in, R5in, R4in, R3in, R2in, R1in};
  assign BusMuxOut = bus;

  // Shared bus: fixed-priority source mux, zero when nothing drives it.
  always_comb begin
    bus = 32'd0;
    if (PCout)         bus = pc;
    else if (MDRout)   bus = mdr;
    else if (ZHighout) bus = zhigh;
    else if (Zlowout)  bus = zlow;
    else if (R2out)    bus = rf[2];
    else if (R3out)    bus = rf[3];
    else if (R4out)    bus = rf[4];
    else if (R5out)    bus = rf[5];
    else if (R6out)    bus = rf[6];
    else if (R7out)    bus = rf[7];
  end

  // Shared ALU helpers: rotates, signed product and guarded signed divide.
  always_comb begin
    amt      = bus[4:0];
    rol_w    = {y, y} << amt;
    ror_w    = {y, y} >> amt;
    prod     = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});
    div_zero = (bus == 32'd0);
    div_ovf  = (y == 32'h8000_0000) && (bus == 32'hFFFF_FFFF);
    quo      = 32'sd0;
    rem      = 32'sd0;
    // Skip the divider for the two special cases so no X ever leaks out.
    if (!div_zero && !div_ovf) begin
      quo = $signed(y) / $signed(bus);
      rem = $signed(y) % $signed(bus);
    end
  end

  // ALU: A = Y, B = bus, 64-bit result {hi, lo}; unknown opcodes give zero.
  always_comb begin
    alu_res = 64'd0;
    case (DIV)
      5'b00011: alu_res = {32'd0, y + bus + {31'd0, Cin}};
      5'b00100: alu_res = {32'd0, y - bus};
      5'b00101: alu_res = {32'd0, y & bus};
      5'b00110: alu_res = {32'd0, y | bus};
      5'b00111: alu_res = {32'd0, ror_w[31:0]};
      5'b01000: alu_res = {32'd0, rol_w[63:32]};
      5'b01001: alu_res = {32'd0, y >> amt};
      5'b01010: alu_res = {32'd0, 32'($signed(y) >>> amt)};
      5'b01011: alu_res = {32'd0, y << amt};
      5'b01111: alu_res = prod;
      5'b10000: begin
        if (div_zero)     alu_res = {y, 32'hFFFF_FFFF};
        else if (div_ovf) alu_res = {32'd0, 32'h8000_0000};
        else              alu_res = {rem, quo};
      end
      5'b10001: alu_res = {32'd0, 32'd0 - bus};
      5'b10010: alu_res = {32'd0, ~bus};
      default:  alu_res = 64'd0;
    endcase
  end

  // Register loads; a synchronous Clear wins over every strobe.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      for (int i = 1; i < 16; i++) rf[i] <= 32'd0;
      pc    <= 32'd0;
      ir    <= 32'd0;
      mar   <= 32'd0;
      mdr   <= 32'd0;
      y     <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      zhigh <= 32'd0;
      zlow  <= 32'd0;
    end else begin
      for (int i = 1; i < 16; i++) if (rf_in[i]) rf[i] <= bus;
      // Increment takes precedence over a bus load of the PC.
      if (IncPC)        pc <= pc + 32'd1;
      else if (PCin)    pc <= bus;
      if (IRin)         ir <= bus;
      if (MARin)        mar <= bus;
      if (MDRin)        mdr <= Read ? Mdatain : bus;
      if (Yin)          y <= bus;
      if (HIin)         hi <= bus;
      if (LOin)         lo <= bus;
      if (ZHighIn)      zhigh <= alu_res[63:32];
      if (ZLowIn)       zlow <= alu_res[31:0];
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: stimulus pushes expected values, a negedge monitor pops and compares.
// Each step drives controls 1 ns after a rising edge; observations are sampled on the falling edge.
// Register contents are read out over the bus where a source select exists, otherwise by peeking.
module tb_data_path;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        PCout, ZHighout, Zlowout, MDRout;
  logic [7:2]  rout;
  logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic [4:0]  DIV;
  logic [15:1] rin;
  logic        HIin, LOin, ZHighIn, ZLowIn, Cin;
  logic [31:0] Mdatain;
  wire  [31:0] BusMuxOut;

  typedef struct {
    int          kind;   // 0 bus, 1 R1, 2 MAR, 3 IR
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic obs = 1'b0;

  always #5 Clock = ~Clock;

  data_path dut (
    .Clock(Clock), .Clear(Clear),
    .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R2out(rout[2]), .R3out(rout[3]), .R4out(rout[4]), .R5out(rout[5]),
    .R6out(rout[6]), .R7out(rout[7]),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .DIV(DIV),
    .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]), .R4in(rin[4]), .R5in(rin[5]),
    .R6in(rin[6]), .R7in(rin[7]), .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]),
    .R11in(rin[11]), .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Cin(Cin),
    .Mdatain(Mdatain), .BusMuxOut(BusMuxOut)
  );

  // Monitor: whenever an observation is flagged, pop the oldest expectation and compare.
  always @(negedge Clock) begin
    exp_t        e;
    logic [31:0] act;
    if (obs) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: observation with no expected value queued");
      end else begin
        e = sb.pop_front();
        case (e.kind)
          0:       act = BusMuxOut;
          1:       act = dut.rf[1];
          2:       act = dut.mar;
          default: act = dut.ir;
        endcase
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic idle_ctl();
    Clear = 1'b1;
    PCout = 0; ZHighout = 0; Zlowout = 0; MDRout = 0; rout = '0;
    MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0; IncPC = 0; Read = 0;
    DIV = 5'd0; rin = '0; HIin = 0; LOin = 0; ZHighIn = 0; ZLowIn = 0; Cin = 0;
    obs = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle_ctl();
  endtask

  // Caller sets the bus select; this queues the expectation and spends one cycle.
  task automatic check_bus(input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = 0; e.exp = exp; e.name = name;
    sb.push_back(e);
    obs = 1'b1;
    tick();
  endtask

  task automatic check_peek(input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.kind = kind; e.exp = exp; e.name = name;
    sb.push_back(e);
    obs = 1'b1;
    tick();
  endtask

  // Memory -> MDR -> Rn, two register transfers.
  task automatic load_r(input int idx, input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
    MDRout = 1; rin[idx] = 1;
    tick();
  endtask

  // Y <= R2 (a), then Z <= ALU(Y, R3 = b).
  task automatic alu_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input logic cin);
    load_r(2, a);
    load_r(3, b);
    rout[2] = 1; Yin = 1;
    tick();
    rout[3] = 1; DIV = op; Cin = cin; ZLowIn = 1; ZHighIn = 1;
    tick();
  endtask

  task automatic check_z(input logic [31:0] lo_exp, input logic [31:0] hi_exp, input string name);
    Zlowout = 1;
    check_bus(lo_exp, {name, "_lo"});
    ZHighout = 1;
    check_bus(hi_exp, {name, "_hi"});
  endtask

  // R4out+Yin; R5out+div into Z; Zlowout+R1in.
  task automatic div_seq(input logic [31:0] a, input logic [31:0] b);
    load_r(4, a);
    load_r(5, b);
    rout[4] = 1; Yin = 1;
    tick();
    rout[5] = 1; DIV = 5'b10000; ZLowIn = 1; ZHighIn = 1;
    tick();
    Zlowout = 1; rin[1] = 1;
    tick();
  endtask

  initial begin
    idle_ctl();
    Mdatain = 32'd0;
    Clear = 1'b0;
    tick();
    Clear = 1'b0;
    tick();

    // Reset after arbitrary loads.
    load_r(2, 32'hDEAD_BEEF);
    Mdatain = 32'h0000_0077; Read = 1; MDRin = 1;
    tick();
    MDRout = 1; PCin = 1;
    tick();
    alu_op(32'd5, 32'd6, 5'b00011, 1'b0);
    Clear = 1'b0;
    tick();
    Clear = 1'b0;
    tick();
    check_bus(32'd0, "reset_bus_idle");
    PCout = 1;    check_bus(32'd0, "reset_pc");
    rout[2] = 1;  check_bus(32'd0, "reset_r2");
    MDRout = 1;   check_bus(32'd0, "reset_mdr");
    Zlowout = 1;  check_bus(32'd0, "reset_zlow");

    // Fetch from PC = 0.
    PCout = 1; MARin = 1; IncPC = 1;
    tick();
    check_peek(2, 32'd0, "fetch_mar");
    PCout = 1;    check_bus(32'd1, "fetch_pc_inc");
    Mdatain = 32'h2891_8000; Read = 1; MDRin = 1;
    tick();
    MDRout = 1; IRin = 1;
    tick();
    check_peek(3, 32'h2891_8000, "fetch_ir");

    // Divide.
    load_r(1, 32'h18);
    div_seq(32'h12, 32'h14);
    check_peek(1, 32'd0, "div_r1");
    check_z(32'd0, 32'h12, "div_18_20");
    div_seq(32'h14, 32'h12);
    check_z(32'd1, 32'd2, "div_20_18");
    check_peek(1, 32'd1, "div_swapped_r1");
    div_seq(32'h14, 32'd0);
    check_z(32'hFFFF_FFFF, 32'h14, "div_by_zero");
    div_seq(32'h8000_0000, 32'hFFFF_FFFF);
    check_z(32'h8000_0000, 32'd0, "div_overflow");
    div_seq(32'hFFFF_FFF9, 32'd2);
    check_z(32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_neg7_2");

    // Multiply.
    alu_op(32'hFFFF_FFFE, 32'd3, 5'b01111, 1'b0);
    check_z(32'hFFFF_FFFA, 32'hFFFF_FFFF, "mul_m2_3");

    // Add / sub / shifts / rotates / misc.
    alu_op(32'hFFFF_FFFF, 32'd1, 5'b00011, 1'b0);
    check_z(32'd0, 32'd0, "add_wrap");
    alu_op(32'd5, 32'd7, 5'b00011, 1'b1);
    Zlowout = 1;  check_bus(32'd13, "add_cin");
    alu_op(32'd5, 32'd7, 5'b00100, 1'b0);
    Zlowout = 1;  check_bus(32'hFFFF_FFFE, "sub");
    alu_op(32'h8000_0000, 32'd4, 5'b01010, 1'b0);
    Zlowout = 1;  check_bus(32'hF800_0000, "shra");
    alu_op(32'h8000_0000, 32'd4, 5'b01001, 1'b0);
    Zlowout = 1;  check_bus(32'h0800_0000, "shr");
    alu_op(32'h8000_0001, 32'd1, 5'b01000, 1'b0);
    Zlowout = 1;  check_bus(32'h0000_0003, "rol");
    alu_op(32'h0000_0001, 32'd1, 5'b00111, 1'b0);
    Zlowout = 1;  check_bus(32'h8000_0000, "ror");
    alu_op(32'h0000_000F, 32'h0000_0003, 5'b01011, 1'b0);
    Zlowout = 1;  check_bus(32'h0000_0078, "shl");
    alu_op(32'h0, 32'd5, 5'b10001, 1'b0);
    Zlowout = 1;  check_bus(32'hFFFF_FFFB, "neg");
    alu_op(32'h0, 32'h0F0F_0000, 5'b10010, 1'b0);
    Zlowout = 1;  check_bus(32'hF0F0_FFFF, "not");
    alu_op(32'hFF00_FF00, 32'h0FF0_0FF0, 5'b00101, 1'b0);
    Zlowout = 1;  check_bus(32'h0F00_0F00, "and");
    alu_op(32'hFF00_FF00, 32'h0FF0_0FF0, 5'b00000, 1'b0);
    check_z(32'd0, 32'd0, "bad_opcode");

    // Bus priority and same-cycle read/write.
    load_r(6, 32'h6666_6666);
    PCout = 1; MDRout = 1; rout[6] = 1;
    check_bus(32'd1, "prio_pc_over_mdr");
    MDRout = 1; rout[6] = 1;
    check_bus(32'h6666_6666, "prio_mdr_over_r6");
    rout[6] = 1; rout[7] = 1; rin[6] = 1;
    tick();
    rout[6] = 1;  check_bus(32'h6666_6666, "self_load_r6");

    // Reset mid-transfer discards the load.
    load_r(7, 32'h1234_5678);
    rout[7] = 1; rin[6] = 1; Clear = 1'b0;
    tick();
    rout[6] = 1;  check_bus(32'd0, "reset_overrides_load");

    tick();
    tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
